arbitro_mux: RTL

Round-robin arbiter sharing the 8:1 byte multiplexer among eight requesters. Each cycle the output register is free, the block picks one requesting channel, drives the mux selector, and captures that channel's byte into a registered output. The output uses a valid/ready handshake toward the consumer. The block sits between the eight byte producers and the single downstream byte sink.

---
 rtl/arbitro_pkg.sv | 36 +++
 rtl/arbitro_mux_mux.sv | 32 +++
 rtl/arbitro_mux.sv | 108 ++++++++++
 3 files changed

// File: rtl/arbitro_pkg.sv
// Shared types and the round-robin search helper for the arbitro_mux block.
// Optional burst support in the top is selected with the ARBITRO_BURST_EN macro.
package arbitro_pkg;

    localparam int N_REQ = 8;
    localparam int SEL_W = 3;

    typedef logic [7:0] byte_t;

    typedef enum logic {
        VAZIO = 1'b0,
        CHEIO = 1'b1
    } estado_t;

    typedef struct packed {
        logic             found;
        logic [SEL_W-1:0] idx;
    } grant_t;

    // First requester at or after ptr, wrapping 7 -> 0.
    function automatic grant_t prox_rr(input logic [N_REQ-1:0] req,
                                       input logic [SEL_W-1:0] ptr);
        grant_t           g;
        logic [SEL_W-1:0] i;
        g = '{found: 1'b0, idx: '0};
        for (int k = N_REQ - 1; k >= 0; k--) begin
            i = ptr + SEL_W'(k);
            if (req[i]) begin
                g.found = 1'b1;
                g.idx   = i;
            end
        end
        return g;
    endfunction

endpackage

// File: rtl/arbitro_mux_mux.sv
// Plain 8:1 byte multiplexer; C1..C8 map to selector values 0..7.
module Mux
    import arbitro_pkg::*;
(
    input  byte_t            C1,
    input  byte_t            C2,
    input  byte_t            C3,
    input  byte_t            C4,
    input  byte_t            C5,
    input  byte_t            C6,
    input  byte_t            C7,
    input  byte_t            C8,
    input  logic [SEL_W-1:0] Seletor,
    output byte_t            Saida
);

    always_comb begin
        Saida = C1;
        case (Seletor)
            3'd0: Saida = C1;
            3'd1: Saida = C2;
            3'd2: Saida = C3;
            3'd3: Saida = C4;
            3'd4: Saida = C5;
            3'd5: Saida = C6;
            3'd6: Saida = C7;
            3'd7: Saida = C8;
            default: Saida = C1;
        endcase
    end

endmodule

// File: rtl/arbitro_mux.sv
// Round-robin arbiter over eight byte producers feeding one registered valid/ready output.
// Define ARBITRO_BURST_EN to let a granted channel keep the output for up to BURST_MAX loads.
module arbitro_mux
    import arbitro_pkg::*;
#(
    parameter int BURST_MAX = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_REQ-1:0]       req,
    input  byte_t [N_REQ-1:0]      dado,
    output logic [N_REQ-1:0]       ack,
    output logic [SEL_W-1:0]       sel,
    output byte_t                  saida,
    output logic                   saida_valid,
    input  logic                   saida_ready
);

    // Handshake: saida is transferred on any cycle where saida_valid && saida_ready;
    // while saida_valid && !saida_ready, saida and sel hold and no new byte is taken.

    estado_t          estado_q, estado_d;
    logic [SEL_W-1:0] ptr_q;
    logic [SEL_W-1:0] sel_q;
    byte_t            saida_q;
    byte_t            mux_out;
    grant_t           rr;
    logic [SEL_W-1:0] g;
    logic             load;
    logic             burst_hit;

    assign rr = prox_rr(req, ptr_q);

`ifdef ARBITRO_BURST_EN
    logic [3:0] cnt_q;

    // Re-grant the previous channel while its burst budget lasts.
    assign burst_hit = (cnt_q != 4'd0) && (cnt_q < 4'(BURST_MAX)) && req[sel_q];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= 4'd0;
        end else if (load) begin
            cnt_q <= burst_hit ? cnt_q + 4'd1 : 4'd1;
        end
    end
`else
    logic [3:0] unused_burst_max;

    assign unused_burst_max = 4'(BURST_MAX);
    assign burst_hit        = 1'b0;
`endif

    assign g = burst_hit ? sel_q : rr.idx;

    Mux u_mux (
        .C1      (dado[0]),
        .C2      (dado[1]),
        .C3      (dado[2]),
        .C4      (dado[3]),
        .C5      (dado[4]),
        .C6      (dado[5]),
        .C7      (dado[6]),
        .C8      (dado[7]),
        .Seletor (g),
        .Saida   (mux_out)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado_q <= VAZIO;
        end else begin
            estado_q <= estado_d;
        end
    end

    always_comb begin
        estado_d = estado_q;
        case (estado_q)
            VAZIO: if (load) estado_d = CHEIO;
            CHEIO: if (saida_ready && !load) estado_d = VAZIO;
            default: estado_d = VAZIO;
        endcase
    end

    always_comb begin
        saida_valid = (estado_q == CHEIO);
        load        = rr.found && (!saida_valid || saida_ready);
        ack         = '0;
        if (load) ack[g] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q   <= '0;
            sel_q   <= '0;
            saida_q <= '0;
        end else if (load) begin
            saida_q <= mux_out;
            sel_q   <= g;
            if (!burst_hit) ptr_q <= g + SEL_W'(1);
        end
    end

    assign sel   = sel_q;
    assign saida = saida_q;

endmodule
